// File: rtl/goal_pkg.sv
// Purpose: shared types and constants for the goal detector (FSM states, goal codes, coordinate widths).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package goal_pkg;

  // Ball coordinates arrive as 11-bit signed values; centre maths uses one extra bit.
  localparam int COORD_W  = 11;
  localparam int CENTRE_W = COORD_W + 1;

  // Detector FSM states; the raw encoding is exported on detectState for debug.
  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    SCORED     = 2'd1,
    HOLD       = 2'd2,
    WAIT_CLEAR = 2'd3
  } goal_state_e;

  // goalWasScored codes; 2'b11 is never produced.
  localparam logic [1:0] GOAL_NONE  = 2'b00;
  localparam logic [1:0] GOAL_RIGHT = 2'b01;
  localparam logic [1:0] GOAL_LEFT  = 2'b10;

  // Collapse the two zone flags into a goal code. Both flags set means the
  // goal parameters overlap, which is treated as "no zone" rather than guessed.
  function automatic logic [1:0] zone_code(input logic in_left, input logic in_right);
    logic [1:0] code;
    code = GOAL_NONE;
    if (in_right && !in_left) begin
      code = GOAL_RIGHT;
    end else if (in_left && !in_right) begin
      code = GOAL_LEFT;
    end
    return code;
  endfunction

endpackage

// File: rtl/goal_zone_check.sv
// Purpose: combinational ball-centre computation and left/right goal-mouth membership test.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
module goal_zone_check
  import goal_pkg::*;
#(
  parameter int BALL_W        = 32,
  parameter int BALL_H        = 64,
  parameter int LEFT_GOAL_X   = 32,
  parameter int RIGHT_GOAL_X  = 603,
  parameter int GOAL_TOP_Y    = 205,
  parameter int GOAL_BOTTOM_Y = 269
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic               o_in_left,
  output logic               o_in_right
);

  // Thresholds pre-sized to the centre width so every compare is signed-vs-signed.
  localparam logic signed [CENTRE_W-1:0] C_HALF_W = CENTRE_W'(BALL_W / 2);
  localparam logic signed [CENTRE_W-1:0] C_HALF_H = CENTRE_W'(BALL_H / 2);
  localparam logic signed [CENTRE_W-1:0] C_LEFT   = CENTRE_W'(LEFT_GOAL_X);
  localparam logic signed [CENTRE_W-1:0] C_RIGHT  = CENTRE_W'(RIGHT_GOAL_X);
  localparam logic signed [CENTRE_W-1:0] C_TOP    = CENTRE_W'(GOAL_TOP_Y);
  localparam logic signed [CENTRE_W-1:0] C_BOTTOM = CENTRE_W'(GOAL_BOTTOM_Y);

  logic signed [CENTRE_W-1:0] w_cx;
  logic signed [CENTRE_W-1:0] w_cy;
  logic                       w_in_y;
  logic                       w_raw_left;
  logic                       w_raw_right;

  // Sign-extend by one bit before adding the half-size so a ball near the
  // positive edge of the 11-bit range cannot wrap negative.
  assign w_cx = $signed({i_x[COORD_W-1], i_x}) + C_HALF_W;
  assign w_cy = $signed({i_y[COORD_W-1], i_y}) + C_HALF_H;

  // Both goal mouths share the same vertical band (inclusive at both ends).
  assign w_in_y = (w_cy >= C_TOP) && (w_cy <= C_BOTTOM);

  // Right goal is inclusive at its threshold, left goal is strict.
  assign w_raw_right = w_in_y && (w_cx >= C_RIGHT);
  assign w_raw_left  = w_in_y && (w_cx <  C_LEFT);

  // Overlapping zones can only come from bad parameters; report neither.
  assign o_in_right = w_raw_right && !w_raw_left;
  assign o_in_left  = w_raw_left  && !w_raw_right;

endmodule

// File: rtl/goal_detector.sv
// Purpose: per-frame goal detection FSM; pulses goalWasScored once per goal, then holds off
//          (ballResetReq) for HOLD_FRAMES frames and waits for the ball to leave both goals.
// Latency: goal pulse 1 cycle after the confirming startOfFrame. Backpressure: none.
// Build option: define GOAL_DEBOUNCE_EN to require CONFIRM_FRAMES consecutive in-zone frames;
//               left undefined, the first enabled in-zone frame in PLAY scores.
module goal_detector
  import goal_pkg::*;
#(
  parameter int BALL_W         = 32,
  parameter int BALL_H         = 64,
  parameter int LEFT_GOAL_X    = 32,
  parameter int RIGHT_GOAL_X   = 603,
  parameter int GOAL_TOP_Y     = 205,
  parameter int GOAL_BOTTOM_Y  = 269,
  parameter int CONFIRM_FRAMES = 2,
  parameter int HOLD_FRAMES    = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        gameEnable,
  input  logic [10:0] ballTopLeftX,
  input  logic [10:0] ballTopLeftY,
  output logic [1:0]  goalWasScored,
  output logic        ballResetReq,
  output logic [1:0]  detectState
);

  // Parameter legality: counters are 4 bits (confirm) and 8 bits (hold), and
  // zero would make the FSM skip a state it relies on.
  if (CONFIRM_FRAMES < 1 || CONFIRM_FRAMES > 15) begin : g_bad_confirm
    $error("goal_detector: CONFIRM_FRAMES must be in 1..15");
  end
  if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_bad_hold
    $error("goal_detector: HOLD_FRAMES must be in 1..255");
  end

  localparam logic [7:0] C_HOLD = 8'(HOLD_FRAMES);

  goal_state_e r_state;
  logic [1:0]  r_goal;
  logic        r_req;
  logic [7:0]  r_hold_cnt;

  logic        w_in_left;
  logic        w_in_right;
  logic [1:0]  w_zone;
  logic [1:0]  w_en_zone;
  logic        w_confirmed;

  goal_zone_check #(
    .BALL_W        (BALL_W),
    .BALL_H        (BALL_H),
    .LEFT_GOAL_X   (LEFT_GOAL_X),
    .RIGHT_GOAL_X  (RIGHT_GOAL_X),
    .GOAL_TOP_Y    (GOAL_TOP_Y),
    .GOAL_BOTTOM_Y (GOAL_BOTTOM_Y)
  ) u_zone (
    .i_x        (ballTopLeftX),
    .i_y        (ballTopLeftY),
    .o_in_left  (w_in_left),
    .o_in_right (w_in_right)
  );

  // Zone as a goal code; gated by gameEnable only where PLAY consumes it.
  assign w_zone    = zone_code(w_in_left, w_in_right);
  assign w_en_zone = gameEnable ? w_zone : GOAL_NONE;

`ifdef GOAL_DEBOUNCE_EN
  localparam logic [3:0] C_CONFIRM = 4'(CONFIRM_FRAMES);

  logic [3:0] r_confirm_cnt;
  logic [1:0] r_prev_zone;
  logic [3:0] w_confirm_nxt;

  // Next run length of consecutive same-zone frames; a zone change restarts
  // at 1, leaving the zones (or disabling the game) drops it to 0.
  always_comb begin
    w_confirm_nxt = 4'd0;
    if (w_en_zone != GOAL_NONE) begin
      if (w_en_zone == r_prev_zone) begin
        w_confirm_nxt = 4'(r_confirm_cnt + 4'd1);
      end else begin
        w_confirm_nxt = 4'd1;
      end
    end
  end

  // The run never exceeds C_CONFIRM because reaching it leaves PLAY.
  assign w_confirmed = (w_en_zone != GOAL_NONE) && (w_confirm_nxt >= C_CONFIRM);
`else
  // No debounce: any enabled in-zone frame confirms immediately.
  assign w_confirmed = (w_en_zone != GOAL_NONE);
`endif

  // Detector FSM: state, registered outputs and the frame counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= PLAY;
      r_goal     <= GOAL_NONE;
      r_req      <= 1'b0;
      r_hold_cnt <= 8'd0;
`ifdef GOAL_DEBOUNCE_EN
      r_confirm_cnt <= 4'd0;
      r_prev_zone   <= GOAL_NONE;
`endif
    end else begin
      // goalWasScored is a single-cycle pulse; it is re-armed only on entry to SCORED.
      r_goal <= GOAL_NONE;
      case (r_state)
        PLAY: begin
          if (startOfFrame) begin
`ifdef GOAL_DEBOUNCE_EN
            r_confirm_cnt <= w_confirm_nxt;
            r_prev_zone   <= w_en_zone;
`endif
            if (w_confirmed) begin
              r_state <= SCORED;
              r_goal  <= w_en_zone;
`ifdef GOAL_DEBOUNCE_EN
              // Start the next rally with a clean run history.
              r_confirm_cnt <= 4'd0;
              r_prev_zone   <= GOAL_NONE;
`endif
            end
          end
        end

        SCORED: begin
          // A frame landing in this cycle is deliberately not counted toward the hold.
          r_hold_cnt <= C_HOLD;
          r_req      <= 1'b1;
          r_state    <= HOLD;
        end

        HOLD: begin
          if (startOfFrame) begin
            if (r_hold_cnt <= 8'd1) begin
              r_hold_cnt <= 8'd0;
              r_req      <= 1'b0;
              r_state    <= WAIT_CLEAR;
            end else begin
              r_hold_cnt <= r_hold_cnt - 8'd1;
            end
          end
        end

        WAIT_CLEAR: begin
          // A ball still parked in a net must not score twice; wait for it to leave.
          if (startOfFrame && (w_zone == GOAL_NONE)) begin
            r_state <= PLAY;
          end
        end

        default: begin
          r_state <= PLAY;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign goalWasScored = r_goal;
  assign ballResetReq  = r_req;
  assign detectState   = r_state;

endmodule
